// File: rtl/skewed_input_buffer.sv
// skewed_input_buffer: ROWS x DEPTH operand buffer streaming a column window to the array rows; SKEW_INBUF_SKEW_EN enables diagonal row skew
module skewed_input_buffer #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int DEPTH  = 256,
  parameter int COL_W  = $clog2(DEPTH),
  parameter int ADDR_W = $clog2(ROWS*DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   start,
  input  logic [COL_W-1:0]       start_col,
  input  logic [COL_W:0]         len,
  output logic                   busy,
  output logic                   out_valid,
  output logic [ROWS*DATA_W-1:0] out_data,
  output logic                   done
);
  localparam int RW = $clog2(ROWS);
`ifdef SKEW_INBUF_SKEW_EN
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;
`endif
  state_t state_q, state_d;
  logic [COL_W:0] cnt_q, cnt_d, len_q, len_d;
  logic [COL_W-1:0] col_q, col_d, rd_col;
  logic rd_en;
  logic [ROWS-1:0] out_vld;
  logic [DATA_W-1:0] mem [ROWS][DEPTH];
  // storage is never cleared; low address bits select the row, high bits the column
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr[RW-1:0]][wr_addr[ADDR_W-1:RW]] <= wr_data;
  assign rd_col = col_q + cnt_q[COL_W-1:0];
  assign rd_en = (state_q == STREAM) && (cnt_q < len_q);
`ifdef SKEW_INBUF_SKEW_EN
  assign busy = (state_q == STREAM) || (state_q == DRAIN);
`else
  assign busy = state_q == STREAM;
`endif
  assign done = state_q == FIN;
  assign out_valid = |out_vld;
  // STREAM spends len read cycles plus one cycle letting the output register settle;
  // a zero-length window passes through that single cycle straight to FIN
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    col_d = col_q;
    len_d = len_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = start ? STREAM : IDLE;
        cnt_d = start ? '0 : cnt_q;
        col_d = start ? start_col : col_q;
        len_d = start ? len : len_q;
      end
      STREAM: begin
`ifdef SKEW_INBUF_SKEW_EN
        state_d = (cnt_q != len_q) ? STREAM : (len_q == '0) ? FIN : DRAIN;
`else
        state_d = (cnt_q != len_q) ? STREAM : FIN;
`endif
        cnt_d = (cnt_q != len_q) ? cnt_q + (COL_W+1)'(1) : '0;
      end
`ifdef SKEW_INBUF_SKEW_EN
      DRAIN: begin
        state_d = (cnt_q == (COL_W+1)'(ROWS-2)) ? FIN : DRAIN;
        cnt_d = cnt_q + (COL_W+1)'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // control state register
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      col_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      len_q <= len_d;
    end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] rd, q;
    logic v;
    assign rd = rd_en ? mem[r][rd_col] : '0;
    assign out_data[r*DATA_W +: DATA_W] = q;
    assign out_vld[r] = v;
`ifdef SKEW_INBUF_SKEW_EN
    if (r == 0) begin : g_direct
      // row 0 goes straight to its output register
      always_ff @(posedge clk) begin
        q <= rst ? '0 : rd;
        v <= rst ? 1'b0 : rd_en;
      end
    end else begin : g_skew
      logic [DATA_W-1:0] sd [r];
      logic [r-1:0] sv;
      // r-deep delay line; zeros ride along outside the window so padding is automatic
      always_ff @(posedge clk)
        if (rst) begin
          for (int i = 0; i < r; i++) sd[i] <= '0;
          sv <= '0;
          q <= '0;
          v <= 1'b0;
        end else begin
          sd[0] <= rd;
          sv[0] <= rd_en;
          for (int i = 1; i < r; i++) begin
            sd[i] <= sd[i-1];
            sv[i] <= sv[i-1];
          end
          q <= sd[r-1];
          v <= sv[r-1];
        end
    end
`else
    // aligned mode: every row registers its read directly
    always_ff @(posedge clk) begin
      q <= rst ? '0 : rd;
      v <= rst ? 1'b0 : rd_en;
    end
`endif
  end
endmodule

// File: tb/tb_skewed_input_buffer.sv
// tb_skewed_input_buffer: randomized directed checks of skewed_input_buffer against a window/timing model
module tb_skewed_input_buffer;
  localparam int DATA_W = 16, ROWS = 4, DEPTH = 256, COL_W = 8, ADDR_W = 10;
  localparam int W = ROWS*DATA_W;
`ifdef SKEW_INBUF_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [COL_W-1:0] start_col = '0;
  logic [COL_W:0] len = '0;
  logic busy, out_valid, done;
  logic [W-1:0] out_data;
  int checks = 0, failures = 0;
  logic [DATA_W-1:0] ref_mem [ROWS][DEPTH];
  logic [DATA_W-1:0] snap [ROWS][DEPTH];

  skewed_input_buffer #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_col(start_col), .len(len), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .done(done));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_data(input int sc, input int l, input int t);
    logic [W-1:0] e;
    e = '0;
    for (int r = 0; r < ROWS; r++) begin
      int k;
      k = t - 1 - r*SK;
      if (k >= 0 && k < l) e[r*DATA_W +: DATA_W] = snap[r][(sc+k) % DEPTH];
    end
    return e;
  endfunction

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    tick;
    wr_en = 1'b0;
    ref_mem[a % ROWS][a / ROWS] = d;
  endtask

  // one stream: start sampled at the first edge, then every cycle checked until idle (or FIN if chained)
  task automatic run(input int sc, input int l, input bit chain, input int nsc, input int nl,
                     input bit noise, input int wt, input int wa, input logic [DATA_W-1:0] wd);
    int span;
    span = (l == 0) ? 0 : l + SK*(ROWS-1);
    start = 1'b1;
    start_col = COL_W'(sc);
    len = (COL_W+1)'(l);
    snap = ref_mem;
    tick;
    for (int t = 0; t <= span + 2; t++) begin
      if (t == span + 1) begin
        start = chain;
        start_col = COL_W'(nsc);
        len = (COL_W+1)'(nl);
      end else if (t == span + 2) begin
        start = 1'b0;
      end else begin
        start = noise ? 1'($urandom) : 1'b0;
        start_col = COL_W'($urandom);
        len = (COL_W+1)'($urandom);
      end
      wr_en = (t == wt);
      if (t == wt) begin
        wr_addr = ADDR_W'(wa);
        wr_data = wd;
      end
      chk($sformatf("busy sc=%0d l=%0d t=%0d", sc, l, t), W'(busy), W'(t <= span));
      chk($sformatf("done sc=%0d l=%0d t=%0d", sc, l, t), W'(done), W'(t == span + 1));
      chk($sformatf("valid sc=%0d l=%0d t=%0d", sc, l, t), W'(out_valid), W'(t >= 1 && t <= span));
      chk($sformatf("data sc=%0d l=%0d t=%0d", sc, l, t), out_data, exp_data(sc, l, t));
      if (chain && t == span + 1) begin
        wr_en = 1'b0;
        return;
      end
      tick;
      if (t == wt) ref_mem[wa % ROWS][wa / ROWS] = wd;
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick;
    tick;
    tick;
    chk("rst busy", W'(busy), '0);
    chk("rst done", W'(done), '0);
    chk("rst valid", W'(out_valid), '0);
    chk("rst data", out_data, '0);
    rst = 1'b0;
    for (int a = 0; a < ROWS*DEPTH; a++)
      wr(a, (a < 16) ? DATA_W'(16'h1000 + a) : DATA_W'($urandom));
    run(0, 4, 0, 0, 0, 0, -1, 0, '0);
    run(254, 4, 0, 0, 0, 0, -1, 0, '0);
    run(0, 0, 0, 0, 0, 0, -1, 0, '0);
    run(10, 5, 1, 20, 3, 0, -1, 0, '0);
    run(20, 3, 0, 0, 0, 0, -1, 0, '0);
    run(0, 8, 0, 0, 0, 1, 3, 12, 16'hBEEF);
    run(0, 8, 0, 0, 0, 0, -1, 0, '0);
    run(100, DEPTH, 0, 0, 0, 1, -1, 0, '0);
    run(255, 1, 0, 0, 0, 0, -1, 0, '0);
    start = 1'b1;
    start_col = '0;
    len = 9'd8;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort busy", W'(busy), '0);
    chk("abort done", W'(done), '0);
    chk("abort valid", W'(out_valid), '0);
    chk("abort data", out_data, '0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("abort quiet done %0d", i), W'(done), '0);
      chk($sformatf("abort quiet valid %0d", i), W'(out_valid), '0);
      tick;
    end
    run(0, 8, 0, 0, 0, 0, -1, 0, '0);
    for (int i = 0; i < 20; i++)
      run(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 12)), 0, 0, 0,
          1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, ROWS*DEPTH-1)),
          DATA_W'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
